// File: rtl/led_bank_pkg.sv
// ---------------------------------------------------------------------------
// led_bank_pkg
// Shared types and constants for the LED bank arbiter.
//   state_t   : arbiter FSM states (IDLE, GRANT, HANDOFF)
//   LED_ALL_OFF / IDLE_INIT : active-low LED constants for the 6-LED bank
//   rr_pick() : round-robin winner search, returns {valid, idx}
// ---------------------------------------------------------------------------
package led_bank_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    HANDOFF = 2'd2
  } state_t;

  // LEDs are active-low, so all ones means the whole bank is dark.
  localparam logic [5:0] LED_ALL_OFF = '1;
  localparam logic [5:0] IDLE_INIT   = 6'b011111;

  // The search helper works on a fixed maximum width so it can be shared by
  // any NUM_REQ up to MAX_REQ without a parameterised function.
  localparam int MAX_REQ  = 32;
  localparam int RR_IDX_W = 5;

  typedef struct packed {
    logic                valid;
    logic [RR_IDX_W-1:0] idx;
  } rrPick_t;

  // Returns the first asserted request strictly after 'last', wrapping at
  // numReq. 'last' itself is considered last of all, so a lone holder can
  // still win its own slot back.
  function automatic rrPick_t rr_pick(input logic [MAX_REQ-1:0]  req,
                                      input logic [RR_IDX_W-1:0] last,
                                      input int                  numReq);
    rrPick_t             result;
    int                  cand;
    logic [RR_IDX_W-1:0] candIdx;
    result = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      if (k <= numReq && !result.valid) begin
        cand = int'(last) + k;
        if (cand >= numReq) begin
          cand = cand - numReq;
        end
        candIdx = RR_IDX_W'(cand);
        if (req[candIdx]) begin
          result.valid = 1'b1;
          result.idx   = candIdx;
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/led_bank_arbiter_if.sv
// ---------------------------------------------------------------------------
// led_bank_arbiter_if
// Bundles the requester-facing signals of the LED bank arbiter.
//   req     : level request per requester
//   pattern : flat active-low patterns, requester i at [i*LED_WIDTH +: LED_WIDTH]
//   gnt     : one-hot or zero grant
//   busy    : arbiter is not idle
//   tick    : one-cycle prescaler pulse
//   led     : registered active-low LED drive
// master = requester/board side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface led_bank_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int LED_WIDTH = 6
);

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*LED_WIDTH-1:0] pattern;
  logic [NUM_REQ-1:0]           gnt;
  logic                         busy;
  logic                         tick;
  logic [LED_WIDTH-1:0]         led;

  modport master (
    output req,
    output pattern,
    input  gnt,
    input  busy,
    input  tick,
    input  led
  );

  modport slave (
    input  req,
    input  pattern,
    output gnt,
    output busy,
    output tick,
    output led
  );

endinterface

// File: rtl/led_bank_arbiter_tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Free-running prescaler producing a registered one-cycle tick every
// TICK_LIMIT+1 clocks.
//   i_clk   : system clock
//   i_rst_n : synchronous active-low reset
//   o_tick  : high during the cycle the counter sits at TICK_LIMIT
// ---------------------------------------------------------------------------
module tick_prescaler #(
  parameter int unsigned TICK_LIMIT = 24'hFFFFFF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int CNT_W = (TICK_LIMIT > 0) ? $clog2(TICK_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TICK_LIMIT);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_countNext;
  logic             r_tick;

  // Next counter value: count up and wrap back to zero after the terminal
  // count, so the counter can never overflow.
  always_comb begin
    w_countNext = (r_count == LIMIT) ? '0 : r_count + 1'b1;
  end

  // The tick flop is loaded from the next counter value so that the
  // registered pulse lines up with the cycle the counter equals LIMIT.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_count <= w_countNext;
      r_tick  <= (w_countNext == LIMIT);
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/led_bank_arbiter.sv
// ---------------------------------------------------------------------------
// led_bank_arbiter
// Shares the 6-LED bank between NUM_REQ pattern requesters. Round-robin
// arbitration with a minimum dwell (in prescaler ticks) per grant, a one-cycle
// all-off gap on every hand-off, and a walking-zero idle pattern when nobody
// is asking for the LEDs.
//   i_clk   : system clock (internal oscillator)
//   i_rst_n : synchronous active-low reset
//   bus     : slave side of led_bank_arbiter_if (req, pattern, gnt, busy,
//             tick, led)
// ---------------------------------------------------------------------------
module led_bank_arbiter
  import led_bank_pkg::*;
#(
  parameter int          NUM_REQ     = 4,
  parameter int          LED_WIDTH   = 6,
  parameter int unsigned TICK_LIMIT  = 24'hFFFFFF,
  parameter int          DWELL_TICKS = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  led_bank_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int DW_W  = $clog2(DWELL_TICKS + 1);
  localparam logic [DW_W-1:0]      DWELL_MAX = DW_W'(DWELL_TICKS);
  localparam logic [LED_WIDTH-1:0] LED_OFF   = LED_WIDTH'(LED_ALL_OFF);
  localparam logic [LED_WIDTH-1:0] IDLE_PAT  = LED_WIDTH'(IDLE_INIT);

  // Elaboration-time parameter sanity checks.
  if (DWELL_TICKS < 1) begin : gDwellCheck
    $error("led_bank_arbiter: DWELL_TICKS must be at least 1");
  end
  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : gNumReqCheck
    $error("led_bank_arbiter: NUM_REQ must be in 2..32");
  end
  if (LED_WIDTH != $bits(IDLE_INIT)) begin : gWidthCheck
    $error("led_bank_arbiter: LED_WIDTH must match the idle pattern width");
  end

  state_t               r_state;
  state_t               w_nextState;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [NUM_REQ-1:0]   w_gntNext;
  logic [LED_WIDTH-1:0] r_led;
  logic [LED_WIDTH-1:0] w_ledNext;
  logic [LED_WIDTH-1:0] r_idlePattern;
  logic [LED_WIDTH-1:0] w_idleNext;
  logic [LED_WIDTH-1:0] w_idleAdvanced;
  logic [IDX_W-1:0]     r_last;
  logic [IDX_W-1:0]     w_lastNext;
  logic [DW_W-1:0]      r_dwell;
  logic [DW_W-1:0]      w_dwellNext;

  logic [MAX_REQ-1:0]   w_reqWide;
  rrPick_t              w_pick;
  logic [IDX_W-1:0]     w_winnerIdx;
  logic [NUM_REQ-1:0]   w_winnerMask;
  logic [NUM_REQ-1:0]   w_holderMask;
  logic                 w_holderReq;
  logic                 w_otherReq;
  logic [LED_WIDTH-1:0] w_winnerPattern;
  logic [LED_WIDTH-1:0] w_holderPattern;
  logic                 w_tick;

  tick_prescaler #(
    .TICK_LIMIT (TICK_LIMIT)
  ) u_prescaler (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_tick  (w_tick)
  );

  // Arbitration helpers. While granted, r_last is the holder index, so the
  // same pointer doubles as "who owns the bank" and "where the next search
  // starts". The idle walk shifts a single zero right and reloads once the
  // zero has fallen off the LSB.
  always_comb begin
    w_reqWide                = '0;
    w_reqWide[NUM_REQ-1:0]   = bus.req;
    w_pick                   = rr_pick(w_reqWide, RR_IDX_W'(r_last), NUM_REQ);
    w_winnerIdx              = IDX_W'(w_pick.idx);
    w_winnerMask             = NUM_REQ'(1) << w_winnerIdx;
    w_holderMask             = NUM_REQ'(1) << r_last;
    w_holderReq              = |(bus.req & w_holderMask);
    w_otherReq               = |(bus.req & ~w_holderMask);
    w_winnerPattern          = bus.pattern[int'(w_winnerIdx)*LED_WIDTH +: LED_WIDTH];
    w_holderPattern          = bus.pattern[int'(r_last)*LED_WIDTH +: LED_WIDTH];
    w_idleAdvanced           = r_idlePattern[0] ? {1'b1, r_idlePattern[LED_WIDTH-1:1]}
                                                : IDLE_PAT;
  end

  // Next-state and next-output logic. Outputs are computed here as the
  // values the output flops will hold after the edge, which gives the
  // one-cycle grant latency and the one-cycle pattern-follow latency.
  // Leaving GRANT (drop or preemption) goes to HANDOFF whenever someone
  // else is waiting, so every hand-off gets its dark gap; a drop with no
  // one waiting goes straight back to the frozen idle pattern.
  always_comb begin
    w_nextState = r_state;
    w_gntNext   = '0;
    w_ledNext   = r_idlePattern;
    w_dwellNext = r_dwell;
    w_lastNext  = r_last;
    w_idleNext  = r_idlePattern;

    case (r_state)
      IDLE: begin
        if (w_tick) begin
          w_idleNext = w_idleAdvanced;
        end
        if (w_pick.valid) begin
          w_nextState = GRANT;
          w_gntNext   = w_winnerMask;
          w_ledNext   = w_winnerPattern;
          w_dwellNext = '0;
          w_lastNext  = w_winnerIdx;
        end else begin
          w_ledNext = w_idleNext;
        end
      end

      GRANT: begin
        w_gntNext = w_holderMask;
        w_ledNext = w_holderPattern;
        if (w_tick && r_dwell != DWELL_MAX) begin
          w_dwellNext = r_dwell + 1'b1;
        end
        if (!w_holderReq || (r_dwell == DWELL_MAX && w_otherReq)) begin
          w_gntNext = '0;
          if (w_otherReq) begin
            w_nextState = HANDOFF;
            w_ledNext   = LED_OFF;
          end else begin
            w_nextState = IDLE;
            w_ledNext   = r_idlePattern;
          end
        end
      end

      HANDOFF: begin
        if (w_pick.valid) begin
          w_nextState = GRANT;
          w_gntNext   = w_winnerMask;
          w_ledNext   = w_winnerPattern;
          w_dwellNext = '0;
          w_lastNext  = w_winnerIdx;
        end else begin
          w_nextState = IDLE;
          w_ledNext   = r_idlePattern;
        end
      end

      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State and output registers. Reset puts the pointer at the top requester
  // so requester 0 is first in line, and reinitialises the idle walk.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_gnt         <= '0;
      r_led         <= IDLE_PAT;
      r_idlePattern <= IDLE_PAT;
      r_last        <= IDX_W'(NUM_REQ - 1);
      r_dwell       <= '0;
    end else begin
      r_state       <= w_nextState;
      r_gnt         <= w_gntNext;
      r_led         <= w_ledNext;
      r_idlePattern <= w_idleNext;
      r_last        <= w_lastNext;
      r_dwell       <= w_dwellNext;
    end
  end

  assign bus.gnt  = r_gnt;
  assign bus.led  = r_led;
  assign bus.busy = (r_state != IDLE);
  assign bus.tick = w_tick;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_led_bank_arbiter
// Self-checking bench for led_bank_arbiter with TICK_LIMIT=3, DWELL_TICKS=2.
// A behavioural model tracks the owner of the LED bank, the gap cycle, the
// dwell count and the position in the idle walk, and predicts gnt, led,
// busy and tick after every clock edge.
// ---------------------------------------------------------------------------
module tb_led_bank_arbiter;

  localparam int NREQ   = 4;
  localparam int LW     = 6;
  localparam int TL     = 3;
  localparam int DW     = 2;
  localparam int PERIOD = TL + 1;

  logic clk = 1'b0;
  logic rstN;

  led_bank_arbiter_if #(.NUM_REQ(NREQ), .LED_WIDTH(LW)) bus ();

  led_bank_arbiter #(
    .NUM_REQ     (NREQ),
    .LED_WIDTH   (LW),
    .TICK_LIMIT  (TL),
    .DWELL_TICKS (DW)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  logic [LW-1:0] pat [NREQ];
  logic [LW-1:0] idleTable [6] = '{6'b011111, 6'b101111, 6'b110111,
                                   6'b111011, 6'b111101, 6'b111110};

  // Model state: who owns the bank (-1 = nobody), whether this is the dark
  // gap cycle, round-robin pointer, dwell ticks, idle walk position and the
  // number of cycles since reset (drives the tick prediction).
  int            mCycle;
  int            mHolder;
  int            mLast;
  int            mDwell;
  int            mIdleIdx;
  bit            mGap;
  logic [NREQ-1:0] mGnt;
  logic [LW-1:0]   mLed;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // First requester after 'last' in circular order.
  function automatic int modelPick(input logic [NREQ-1:0] r, input int last);
    int c;
    for (int k = 1; k <= NREQ; k++) begin
      c = (last + k) % NREQ;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // Either hand the bank to the next winner or fall back to the idle walk.
  task automatic modelGrantOrIdle(input logic [NREQ-1:0] r);
    int w;
    w = modelPick(r, mLast);
    if (w >= 0) begin
      mHolder = w;
      mLast   = w;
      mDwell  = 0;
      mGnt    = NREQ'(1) << w;
      mLed    = pat[w];
    end else begin
      mHolder = -1;
      mGnt    = '0;
      mLed    = idleTable[mIdleIdx];
    end
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic modelStep(input logic rN, input logic [NREQ-1:0] r);
    bit tickNow;
    bit others;
    bit expired;
    if (!rN) begin
      mCycle   = 0;
      mHolder  = -1;
      mGap     = 0;
      mLast    = NREQ - 1;
      mDwell   = 0;
      mIdleIdx = 0;
      mGnt     = '0;
      mLed     = idleTable[0];
      return;
    end
    tickNow = ((mCycle % PERIOD) == PERIOD - 1);
    mCycle++;
    if (mGap) begin
      mGap = 0;
      modelGrantOrIdle(r);
    end else if (mHolder < 0) begin
      if (tickNow) mIdleIdx = (mIdleIdx + 1) % 6;
      modelGrantOrIdle(r);
    end else begin
      others  = |(r & ~(NREQ'(1) << mHolder));
      expired = (mDwell == DW);
      if (tickNow && mDwell < DW) mDwell++;
      if (!r[mHolder] || (expired && others)) begin
        mHolder = -1;
        mGnt    = '0;
        if (others) begin
          mGap = 1;
          mLed = '1;
        end else begin
          mLed = idleTable[mIdleIdx];
        end
      end else begin
        mLed = pat[mHolder];
      end
    end
  endtask

  // Drive one cycle of inputs, step the model at the edge, compare on the
  // falling edge.
  task automatic applyStimulus(input logic rN, input logic [NREQ-1:0] r);
    rstN    = rN;
    bus.req = r;
    for (int i = 0; i < NREQ; i++) begin
      bus.pattern[i*LW +: LW] = pat[i];
    end
    @(posedge clk);
    modelStep(rN, r);
    @(negedge clk);
    checkOutput("gnt",  32'(bus.gnt),  32'(mGnt));
    checkOutput("led",  32'(bus.led),  32'(mLed));
    checkOutput("busy", 32'(bus.busy), 32'((mHolder >= 0) || mGap));
    checkOutput("tick", 32'(bus.tick), 32'((mCycle % PERIOD) == PERIOD - 1));
  endtask

  logic [NREQ-1:0] reqVal;

  initial begin
    for (int i = 0; i < NREQ; i++) pat[i] = '1;
    rstN        = 1'b0;
    bus.req     = '0;
    bus.pattern = '1;

    // Reset values
    applyStimulus(1'b0, '0);
    applyStimulus(1'b0, '0);
    checkOutput("rstLed",  32'(bus.led),  32'h1F);
    checkOutput("rstGnt",  32'(bus.gnt),  32'h0);
    checkOutput("rstBusy", 32'(bus.busy), 32'h0);

    // Idle walk: first advance at cycle 4, full wrap after six ticks
    repeat (4) applyStimulus(1'b1, '0);
    checkOutput("idleWalk1", 32'(bus.led), 32'h2F);
    repeat (20) applyStimulus(1'b1, '0);
    checkOutput("idleWrap", 32'(bus.led), 32'h1F);
    repeat (6) applyStimulus(1'b1, '0);

    // Single grant and pattern tracking, no preemption of a sole requester
    pat[0] = 6'b101010;
    applyStimulus(1'b1, 4'b0001);
    checkOutput("singleGnt", 32'(bus.gnt), 32'h1);
    checkOutput("singleLed", 32'(bus.led), 32'h2A);
    pat[0] = 6'b010101;
    applyStimulus(1'b1, 4'b0001);
    checkOutput("patFollow", 32'(bus.led), 32'h15);
    repeat (80) applyStimulus(1'b1, 4'b0001);
    checkOutput("noPreempt", 32'(bus.gnt), 32'h1);

    // Contention between requesters 0 and 1
    repeat (2) applyStimulus(1'b1, '0);
    for (int i = 0; i < NREQ; i++) pat[i] = LW'($urandom);
    repeat (40) applyStimulus(1'b1, 4'b0011);

    // Release with nobody waiting
    repeat (10) applyStimulus(1'b1, '0);

    // Reset in the middle of requester 2's grant
    repeat (6) applyStimulus(1'b1, 4'b0100);
    applyStimulus(1'b0, 4'b0101);
    checkOutput("midRstGnt", 32'(bus.gnt), 32'h0);
    checkOutput("midRstLed", 32'(bus.led), 32'h1F);
    applyStimulus(1'b1, 4'b0101);
    checkOutput("midRstWin", 32'(bus.gnt), 32'h1);
    repeat (20) applyStimulus(1'b1, 4'b0101);

    // Wrap-around priority from requester 3 back to requester 0
    applyStimulus(1'b0, '0);
    repeat (3) applyStimulus(1'b1, 4'b1000);
    repeat (20) applyStimulus(1'b1, 4'b1001);

    // Randomised traffic with occasional resets
    reqVal = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) reqVal = NREQ'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) pat[$urandom_range(0, NREQ - 1)] = LW'($urandom);
      applyStimulus(($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1, reqVal);
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
